// File: rtl/mem_stage_if.sv
// EX->MEM->WB handshake, data-SRAM response and hazard buses seen by the MEM stage.
// The slave modport is the MEM stage; the master modport is its environment.
interface mem_stage_if #(
    parameter int ES_TO_MS_BUS_WD = 162,
    parameter int MS_TO_WS_BUS_WD = 126
);
    logic                       flush;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_allowin;
    logic                       ws_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic                       data_sram_data_ok;
    logic [31:0]                data_sram_rdata;
    logic [9:0]                 stall_ms_bus;
    logic [32:0]                forward_ms_bus;
    logic                       ms_exc_eret;

    modport slave (
        input  flush, es_to_ms_valid, es_to_ms_bus, ws_allowin,
               data_sram_data_ok, data_sram_rdata,
        output ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
               stall_ms_bus, forward_ms_bus, ms_exc_eret
    );

    modport master (
        output flush, es_to_ms_valid, es_to_ms_bus, ws_allowin,
               data_sram_data_ok, data_sram_rdata,
        input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus,
               stall_ms_bus, forward_ms_bus, ms_exc_eret
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: waits for data-SRAM load responses, extends/merges load data,
// discards responses of flushed loads and drives the MEM->WB handshake.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 162,
    parameter int MS_TO_WS_BUS_WD = 126,
    parameter int CANCEL_W        = 2
) (
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  ms_if
);
    localparam logic [CANCEL_W-1:0] CNT_MAX = '1;

    logic                       ms_valid_q,   ms_valid_d;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q,        bus_d;
    logic                       have_data_q,  have_data_d;
    logic [31:0]                data_buf_q,   data_buf_d;
    logic [CANCEL_W-1:0]        cancel_cnt_q, cancel_cnt_d;

    logic        exc, eret, res_from_cp0, mem_re;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [2:0]  ld_op;
    logic [31:0] rt_value, alu_result, pc;
    logic        need_data, own_ok, ms_ready_go, ms_allowin, ms_to_ws_valid;
    logic        cnt_inc, cnt_dec;
    logic [31:0] load_data, result;

    assign exc          = bus_q[128];
    assign eret         = bus_q[119];
    assign res_from_cp0 = bus_q[117];
    assign gr_we        = bus_q[108:105];
    assign dest         = bus_q[104:100];
    assign mem_re       = bus_q[99];
    assign ld_op        = bus_q[98:96];
    assign rt_value     = bus_q[95:64];
    assign alu_result   = bus_q[63:32];
    assign pc           = bus_q[31:0];

    function automatic logic [31:0] load_ext(input logic [2:0]  op,
                                             input logic [1:0]  a,
                                             input logic [31:0] d,
                                             input logic [31:0] rt);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{a, 3'b000} +: 8];
        h = a[1] ? d[31:16] : d[15:0];
        case (op)
            3'd1: return {{24{b[7]}}, b};
            3'd2: return {24'h0, b};
            3'd3: return {{16{h[15]}}, h};
            3'd4: return {16'h0, h};
            3'd5: case (a)
                2'd0:    return {d[7:0],  rt[23:0]};
                2'd1:    return {d[15:0], rt[15:0]};
                2'd2:    return {d[23:0], rt[7:0]};
                default: return d;
            endcase
            3'd6: case (a)
                2'd0:    return d;
                2'd1:    return {rt[31:24], d[31:8]};
                2'd2:    return {rt[31:16], d[31:16]};
                default: return {rt[31:8],  d[31:24]};
            endcase
            default: return d;
        endcase
    endfunction

    // A response only belongs to the resident load once all cancelled ones have drained.
    assign need_data      = mem_re && !exc;
    assign own_ok         = ms_if.data_sram_data_ok && (cancel_cnt_q == '0);
    assign ms_ready_go    = !need_data || have_data_q || own_ok;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ms_if.ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;

    assign load_data = have_data_q ? data_buf_q : ms_if.data_sram_rdata;
    assign result    = mem_re ? load_ext(ld_op, alu_result[1:0], load_data, rt_value)
                              : alu_result;

    assign ms_if.ms_allowin     = ms_allowin;
    assign ms_if.ms_to_ws_valid = ms_to_ws_valid;
    assign ms_if.ms_to_ws_bus   = {bus_q[161:100], result, pc};
    assign ms_if.stall_ms_bus   = {ms_valid_q && (|gr_we), gr_we & {4{ms_valid_q}}, dest};
    assign ms_if.forward_ms_bus = {ms_valid_q && ms_ready_go && !res_from_cp0 && !exc, result};
    assign ms_if.ms_exc_eret    = ms_valid_q && (exc || eret);

    // Loads killed by a flush still have a response in flight that must be swallowed.
    assign cnt_inc = ms_if.flush &&
                     ((ms_valid_q && need_data && !have_data_q && !own_ok) ||
                      (ms_if.es_to_ms_valid && ms_allowin &&
                       ms_if.es_to_ms_bus[99] && !ms_if.es_to_ms_bus[128]));
    assign cnt_dec = ms_if.data_sram_data_ok && (cancel_cnt_q != '0);

    always_comb begin
        ms_valid_d   = ms_valid_q;
        bus_d        = bus_q;
        have_data_d  = have_data_q;
        data_buf_d   = data_buf_q;
        cancel_cnt_d = cancel_cnt_q;

        if (ms_if.flush) begin
            ms_valid_d  = 1'b0;
            have_data_d = 1'b0;
        end else begin
            if (ms_allowin) ms_valid_d = ms_if.es_to_ms_valid;
            if (ms_if.es_to_ms_valid && ms_allowin) bus_d = ms_if.es_to_ms_bus;
            if (ms_to_ws_valid && ms_if.ws_allowin) begin
                have_data_d = 1'b0;
            end else if (ms_valid_q && need_data && !have_data_q && own_ok) begin
                have_data_d = 1'b1;
                data_buf_d  = ms_if.data_sram_rdata;
            end
        end

        if (cnt_inc && !cnt_dec) begin
            if (cancel_cnt_q != CNT_MAX) cancel_cnt_d = cancel_cnt_q + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            cancel_cnt_d = cancel_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q   <= 1'b0;
            bus_q        <= '0;
            have_data_q  <= 1'b0;
            data_buf_q   <= '0;
            cancel_cnt_q <= '0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            bus_q        <= bus_d;
            have_data_q  <= have_data_d;
            data_buf_q   <= data_buf_d;
            cancel_cnt_q <= cancel_cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: stimulus pushes expected WB buses,
// an independent monitor pops and compares on every MEM->WB transfer.
module tb_mem_stage;
    logic clk;
    logic resetn;

    mem_stage_if #(.ES_TO_MS_BUS_WD(162), .MS_TO_WS_BUS_WD(126)) dut_if ();

    mem_stage #(.ES_TO_MS_BUS_WD(162), .MS_TO_WS_BUS_WD(126), .CANCEL_W(2)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .ms_if  (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [125:0] exp_q[$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] d;
        logic [31:0] res;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [161:0] mk_bus(input logic exc, input logic mem_re,
                                            input logic [2:0] op, input logic [31:0] rt,
                                            input logic [31:0] alu, input logic [31:0] pc);
        return {(exc ? alu : 32'h0), 1'b0, exc, (exc ? 8'h04 : 8'h00), 1'b0, 1'b0, 1'b0,
                8'h00, 4'hF, 5'd9, mem_re, op, rt, alu, pc};
    endfunction

    function automatic logic [125:0] exp_of(input logic [161:0] b, input logic [31:0] res);
        logic [161:0] t;
        t = b;
        return {t[161:100], res, t[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [161:0] b, input bit push, input logic [31:0] res);
        dut_if.es_to_ms_valid = 1'b1;
        dut_if.es_to_ms_bus   = b;
        if (push) exp_q.push_back(exp_of(b, res));
        tick();
        dut_if.es_to_ms_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_allowin"}, 128'(dut_if.ms_allowin), 128'(1));
        check({tag, "_valid"},   128'(dut_if.ms_to_ws_valid), 128'(0));
        check({tag, "_stall"},   128'(dut_if.stall_ms_bus), 128'(0));
        check({tag, "_fwd"},     128'(dut_if.forward_ms_bus), 128'(0));
        check({tag, "_exceret"}, 128'(dut_if.ms_exc_eret), 128'(0));
    endtask

    always @(negedge clk) begin
        if (resetn && dut_if.ms_to_ws_valid && dut_if.ws_allowin) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ws_transfer", 128'(dut_if.ms_to_ws_bus), 128'(0) - 1);
            end else begin
                check("ws_bus", 128'(dut_if.ms_to_ws_bus), 128'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{3'd2, 32'h0000_0102, 32'h0,         32'h11A2_B3C4, 32'h0000_00A2};
        vecs[1] = '{3'd3, 32'h0000_0202, 32'h0,         32'h8001_7FFF, 32'hFFFF_8001};
        vecs[2] = '{3'd4, 32'h0000_0300, 32'h0,         32'h8001_F00F, 32'h0000_F00F};
        vecs[3] = '{3'd6, 32'h0000_0401, 32'hAABB_CCDD, 32'h1122_3344, 32'hAA11_2233};
        vecs[4] = '{3'd6, 32'h0000_0403, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11};
        vecs[5] = '{3'd5, 32'h0000_0500, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD};
        vecs[6] = '{3'd5, 32'h0000_0502, 32'hAABB_CCDD, 32'h1122_3344, 32'h2233_44DD};
        vecs[7] = '{3'd7, 32'h0000_0602, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344};

        resetn                   = 1'b0;
        dut_if.flush             = 1'b0;
        dut_if.es_to_ms_valid    = 1'b0;
        dut_if.es_to_ms_bus      = '0;
        dut_if.ws_allowin        = 1'b1;
        dut_if.data_sram_data_ok = 1'b0;
        dut_if.data_sram_rdata   = '0;
        repeat (2) tick();
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        resetn = 1'b1;
        tick();

        // ALU op: one-cycle latency
        send(mk_bus(1'b0, 1'b0, 3'd0, 32'h0, 32'h1234_5678, 32'hBFC0_0000), 1'b1, 32'h1234_5678);
        @(negedge clk);
        check("add_valid",   128'(dut_if.ms_to_ws_valid), 128'(1));
        check("add_allowin", 128'(dut_if.ms_allowin), 128'(1));
        check("add_fwd",     128'(dut_if.forward_ms_bus), 128'({1'b1, 32'h1234_5678}));
        tick();

        // lb, a=3, response two cycles after entry
        send(mk_bus(1'b0, 1'b1, 3'd1, 32'h0, 32'h0000_1003, 32'hBFC0_0004), 1'b1, 32'hFFFF_FF80);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("lb_wait_allowin", 128'(dut_if.ms_allowin), 128'(0));
            check("lb_wait_valid",   128'(dut_if.ms_to_ws_valid), 128'(0));
            check("lb_wait_stall9",  128'(dut_if.stall_ms_bus[9]), 128'(1));
            check("lb_wait_fwdv",    128'(dut_if.forward_ms_bus[32]), 128'(0));
            tick();
        end
        dut_if.data_sram_data_ok = 1'b1;
        dut_if.data_sram_rdata   = 32'h80FF_FFFF;
        @(negedge clk);
        check("lb_done_valid", 128'(dut_if.ms_to_ws_valid), 128'(1));
        check("lb_done_fwd",   128'(dut_if.forward_ms_bus), 128'({1'b1, 32'hFFFF_FF80}));
        tick();
        dut_if.data_sram_data_ok = 1'b0;

        // lwl, a=1, WB stalled: data must be buffered
        send(mk_bus(1'b0, 1'b1, 3'd5, 32'hAABB_CCDD, 32'h0000_2001, 32'hBFC0_0008), 1'b1, 32'h3344_CCDD);
        dut_if.data_sram_data_ok = 1'b1;
        dut_if.data_sram_rdata   = 32'h1122_3344;
        dut_if.ws_allowin        = 1'b0;
        @(negedge clk);
        check("lwl_ok_result", 128'(dut_if.ms_to_ws_bus[63:32]), 128'(32'h3344_CCDD));
        tick();
        dut_if.data_sram_data_ok = 1'b0;
        dut_if.data_sram_rdata   = 32'h5555_5555;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("lwl_hold_valid",   128'(dut_if.ms_to_ws_valid), 128'(1));
            check("lwl_hold_result",  128'(dut_if.ms_to_ws_bus[63:32]), 128'(32'h3344_CCDD));
            check("lwl_hold_allowin", 128'(dut_if.ms_allowin), 128'(0));
            tick();
        end
        dut_if.ws_allowin = 1'b1;
        tick();

        // load extension table, response in the first MEM cycle
        foreach (vecs[k]) begin
            send(mk_bus(1'b0, 1'b1, vecs[k].op, vecs[k].rt, vecs[k].alu, 32'hBFC0_1000 + 32'(k * 4)),
                 1'b1, vecs[k].res);
            dut_if.data_sram_data_ok = 1'b1;
            dut_if.data_sram_rdata   = vecs[k].d;
            @(negedge clk);
            check("vec_valid", 128'(dut_if.ms_to_ws_valid), 128'(1));
            tick();
            dut_if.data_sram_data_ok = 1'b0;
        end

        // flush a waiting lw; its late response must be swallowed
        send(mk_bus(1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_3000, 32'hBFC0_2000), 1'b0, 32'h0);
        dut_if.flush = 1'b1;
        tick();
        dut_if.flush = 1'b0;
        @(negedge clk);
        check("flush_valid", 128'(dut_if.ms_to_ws_valid), 128'(0));
        send(mk_bus(1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_3004, 32'hBFC0_2004), 1'b1, 32'h0000_BEEF);
        dut_if.data_sram_data_ok = 1'b1;
        dut_if.data_sram_rdata   = 32'hDEAD_0000;
        @(negedge clk);
        check("stale_discard_valid", 128'(dut_if.ms_to_ws_valid), 128'(0));
        tick();
        dut_if.data_sram_rdata = 32'h0000_BEEF;
        @(negedge clk);
        check("own_after_cancel_valid", 128'(dut_if.ms_to_ws_valid), 128'(1));
        tick();
        dut_if.data_sram_data_ok = 1'b0;
        dut_if.data_sram_rdata   = '0;

        // excepting load: no wait, no forward, never counted as cancelled
        send(mk_bus(1'b1, 1'b1, 3'd3, 32'h0, 32'h0000_1001, 32'hBFC0_3000), 1'b1, 32'h0);
        @(negedge clk);
        check("exc_valid",   128'(dut_if.ms_to_ws_valid), 128'(1));
        check("exc_exceret", 128'(dut_if.ms_exc_eret), 128'(1));
        check("exc_fwdv",    128'(dut_if.forward_ms_bus[32]), 128'(0));
        tick();
        dut_if.es_to_ms_valid = 1'b1;
        dut_if.es_to_ms_bus   = mk_bus(1'b1, 1'b1, 3'd0, 32'h0, 32'h0000_2002, 32'hBFC0_3004);
        dut_if.flush          = 1'b1;
        tick();
        dut_if.es_to_ms_valid = 1'b0;
        dut_if.flush          = 1'b0;
        send(mk_bus(1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_4000, 32'hBFC0_3008), 1'b1, 32'hCAFE_F00D);
        dut_if.data_sram_data_ok = 1'b1;
        dut_if.data_sram_rdata   = 32'hCAFE_F00D;
        @(negedge clk);
        check("post_exc_flush_valid", 128'(dut_if.ms_to_ws_valid), 128'(1));
        tick();
        dut_if.data_sram_data_ok = 1'b0;
        dut_if.data_sram_rdata   = '0;

        // asynchronous reset in the middle of a wait
        send(mk_bus(1'b0, 1'b1, 3'd0, 32'h0, 32'h0000_5000, 32'hBFC0_4000), 1'b0, 32'h0);
        @(negedge clk);
        check("prereset_allowin", 128'(dut_if.ms_allowin), 128'(0));
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1;
        resetn                   = 1'b1;
        dut_if.data_sram_data_ok = 1'b1;
        dut_if.data_sram_rdata   = 32'h0000_0012;
        @(negedge clk);
        check("stray_ok_valid",   128'(dut_if.ms_to_ws_valid), 128'(0));
        check("stray_ok_allowin", 128'(dut_if.ms_allowin), 128'(1));
        tick();
        dut_if.data_sram_data_ok = 1'b0;
        send(mk_bus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0BAD_F00D, 32'hBFC0_4004), 1'b1, 32'h0BAD_F00D);
        @(negedge clk);
        check("postreset_add_valid", 128'(dut_if.ms_to_ws_valid), 128'(1));
        tick();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage of the MIPS core. It sits between the EX stage and wb_stage.
- It is the producer end of the ms_to_ws valid/allowin handshake and of the 126-bit ms_to_ws_bus that wb_stage consumes.
- It waits for data-SRAM responses (data_ok/rdata) for loads issued by EX and performs load extension and LWL/LWR merging.
- It drops responses belonging to flushed loads and feeds stall/forward information to ID.

Parameters:
ES_TO_MS_BUS_WD, 162, width of es_to_ms_bus
MS_TO_WS_BUS_WD, 126, width of ms_to_ws_bus
CANCEL_W, 2, width of the cancelled-response counter

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
flush  in  1  exception/eret flush from WB
es_to_ms_valid  in  1  EX holds a valid instruction
es_to_ms_bus  in  162  fields, MSB first: badvaddr[161:130] bd[129] exc[128] exc_type[127:120] eret[119] cp0_wen[118] res_from_cp0[117] cp0_addr[116:109] gr_we[108:105] dest[104:100] mem_re[99] ld_op[98:96] rt_value[95:64] alu_result[63:32] pc[31:0]
ms_allowin  out  1  MEM can accept from EX this cycle
ws_allowin  in  1  wb_stage can accept
ms_to_ws_valid  out  1  MEM presents a finished instruction
ms_to_ws_bus  out  126  fields: badvaddr[125:94] bd[93] exc[92] exc_type[91:84] eret[83] cp0_wen[82] res_from_cp0[81] cp0_addr[80:73] gr_we[72:69] dest[68:64] result[63:32] pc[31:0]
data_sram_data_ok  in  1  read response strobe
data_sram_rdata  in  32  read data, valid with data_ok
stall_ms_bus  out  10  {ms_valid&&|gr_we, gr_we&{4{ms_valid}}, dest}
forward_ms_bus  out  33  {fwd_valid, result}
ms_exc_eret  out  1  ms_valid&&(exc||eret); EX suppresses store requests

Behaviour:
- Reset: asynchronous on resetn=0. ms_valid=0, bus register=0, have_data=0, data_buf=0, cancel_cnt=0. Outputs: ms_allowin=1, ms_to_ws_valid=0, stall_ms_bus=0, forward_ms_bus=0, ms_exc_eret=0.
- Upstream contract: EX issues a load request only in a cycle where it will transfer into MEM (ms_allowin=1). It issues none when exc=1. At most one live request is outstanding.
- Waiting condition: need_data = mem_re && !exc.
- States, derived from ms_valid/need_data/have_data:
  - EMPTY: ms_valid=0.
  - WAIT: valid, need_data, no data yet.
  - READY: no data needed, or data captured.
- Data capture: data_ok counts as "own" only when cancel_cnt==0.
  - If own data_ok arrives in WAIT, ms_ready_go=1 that cycle and the result uses rdata combinationally.
  - If ws_allowin=0 in that cycle, rdata is latched into data_buf and have_data is set (READY). Later results use data_buf.
  - have_data clears when the instruction leaves.
- Handshake:
  - ms_ready_go = !need_data || have_data || own data_ok.
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go.
  - On es_to_ms_valid&&ms_allowin the bus register loads. ms_valid <= es_to_ms_valid when ms_allowin.
  - Latency: non-load one cycle; load one cycle plus response wait.
- Flush (has priority over all other updates): ms_valid<=0, have_data<=0.
  - cancel_cnt increments if (ms_valid && need_data && !have_data && !own data_ok) or (es_to_ms_valid && ms_allowin && entering mem_re && !entering exc).
  - A data_ok while cancel_cnt>0 is discarded and decrements cancel_cnt. Simultaneous increment and decrement leaves the count unchanged.
  - The count saturates at 2^CANCEL_W-1.
- Result:
  - Non-load: alu_result.
  - Load, with a=alu_result[1:0] and d=load data:
    - ld_op 0 or 7, lw: d.
    - ld_op 1, lb: sign-extend byte a.
    - ld_op 2, lbu: zero-extend byte a.
    - ld_op 3, lh: sign-extend half a[1].
    - ld_op 4, lhu: zero-extend half a[1].
    - ld_op 5, lwl: a=0 {d[7:0],rt[23:0]}; 1 {d[15:0],rt[15:0]}; 2 {d[23:0],rt[7:0]}; 3 d.
    - ld_op 6, lwr: a=0 d; 1 {rt[31:24],d[31:8]}; 2 {rt[31:16],d[31:16]}; 3 {rt[31:8],d[31:24]}.
  - All other fields pass through unchanged.
- Forward: fwd_valid = ms_valid && ms_ready_go && !res_from_cp0 && !exc.

Test Plan:
- Add, alu_result=0x12345678, ws_allowin=1 -> ms_to_ws_valid one cycle after entry, result=0x12345678, ms_allowin stays 1.
- lb, addr[1:0]=3, data_ok 2 cycles after entry with rdata=0x80FFFFFF -> WAIT holds ms_allowin=0, stall_ms_bus[9]=1, forward fwd_valid=0 until data_ok, then result=0xFFFFFF80.
- lwl, a=1, rt=0xAABBCCDD, rdata=0x11223344, ws_allowin=0 for 3 cycles after data_ok -> data_buf holds the data, result=0x3344CCDD stable until ws_allowin=1.
- flush while lw in WAIT; new lw enters next cycle; first data_ok rdata=0xDEAD0000 then second 0x0000BEEF -> first discarded (cancel_cnt 1->0), new lw result=0x0000BEEF.
- Load with exc=1 (AdEL) -> no wait, ms_to_ws_valid next cycle, ms_exc_eret=1, fwd_valid=0, cancel_cnt stays 0 on subsequent flush.
- resetn pulled low mid-WAIT -> all outputs are reset values immediately; the stray data_ok after release is ignored since ms_valid=0.
